lcd_controller: RTL

LCD_CONTROLLER -- requirements
Module: lcd_controller

---
 rtl/lcd_pkg.sv | 22 ++
 rtl/lcd_delay_timer.sv | 18 +
 rtl/lcd_controller.sv | 120 ++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, default timings and HD44780 command bytes for lcd_controller
package lcd_pkg;
  typedef enum logic [2:0] {ST_POWERUP, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT, ST_IDLE} state_t;
  localparam int TIMER_W = 20;
  localparam int DEF_POWERUP_WAIT = 750000;
  localparam int DEF_PULSE_CYCLES = 12;
  localparam int DEF_CMD_WAIT = 2000;
  localparam int DEF_CLEAR_WAIT = 82000;
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME = 8'h02;
  localparam logic [7:0] CMD_LINE0 = 8'h80;
  localparam logic [7:0] CMD_LINE1 = 8'hC0;
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    return i == 2'd0 ? CMD_FUNC_SET : i == 2'd1 ? CMD_DISP_ON : i == 2'd2 ? CMD_ENTRY : CMD_CLEAR;
  endfunction
  function automatic logic is_slow(input logic rs, input logic [7:0] d);
    return !rs && (d == CMD_CLEAR || d == CMD_HOME);
  endfunction
endpackage

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer: loadable down-counter; load_val_i=N makes done_o rise N cycles later
// Ports: clk, reset (async active-low), load_i, load_val_i (cycles), done_o (count reached zero)
module lcd_delay_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = load_i ? load_val_i - 1'b1 : count_q != '0 ? count_q - 1'b1 : count_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) count_q <= '0;
    else count_q <= count_d;
  assign done_o = count_q == '0;
endmodule

// File: rtl/lcd_controller.sv
// lcd_controller: HD44780 8-bit write controller with power-up init, cursor tracking and line wrap
// Ports: clk, reset (async active-low); req_valid/req_rs/req_data/req_ready request handshake;
//        init_done, cursor_col, cursor_line status; lcd_data_bus/lcd_rs/lcd_rw/lcd_e to the panel
module lcd_controller
  import lcd_pkg::*;
#(
  parameter int POWERUP_WAIT = DEF_POWERUP_WAIT,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int CMD_WAIT     = DEF_CMD_WAIT,
  parameter int CLEAR_WAIT   = DEF_CLEAR_WAIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic [3:0] cursor_col,
  output logic       cursor_line,
  output logic [7:0] lcd_data_bus,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e
);
  state_t state_q, state_d;
  logic [2:0] step_q, step_d;
  logic armed_q, wrap_q, wrap_d, init_done_q, init_done_d, rs_q, rs_d, e_q, e_d, line_q, line_d;
  logic [7:0] bus_q, bus_d;
  logic [3:0] col_q, col_d;
  logic tmr_load, tmr_done, init_pend, issue;
  logic [TIMER_W-1:0] tmr_val;
  lcd_delay_timer #(.W(TIMER_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );
  // step_q counts init bytes issued; bit 2 set means all four are out
  assign init_pend = !step_q[2];
  assign issue = state_d == ST_SETUP && state_q != ST_SETUP;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= ST_POWERUP;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_POWERUP: state_d = armed_q && tmr_done ? ST_SETUP : ST_POWERUP;
      ST_SETUP:   state_d = ST_PULSE;
      ST_PULSE:   state_d = tmr_done ? ST_HOLD : ST_PULSE;
      ST_HOLD:    state_d = ST_WAIT;
      ST_WAIT:    state_d = !tmr_done ? ST_WAIT : init_pend || wrap_q ? ST_SETUP : ST_IDLE;
      ST_IDLE:    state_d = req_valid ? ST_SETUP : ST_IDLE;
      default:    state_d = ST_POWERUP;
    endcase
  end
  always_comb begin
    step_d = step_q;
    wrap_d = wrap_q;
    bus_d = bus_q;
    rs_d = rs_q;
    col_d = col_q;
    line_d = line_q;
    e_d = state_d == ST_PULSE;
    init_done_d = init_done_q | (state_d == ST_IDLE);
    // the timer is shared: armed_q low marks the first power-up cycle, where the long wait is loaded
    tmr_load = !armed_q || state_q == ST_SETUP || state_q == ST_HOLD;
    tmr_val = !armed_q ? TIMER_W'(POWERUP_WAIT - 1) : state_q == ST_SETUP ? TIMER_W'(PULSE_CYCLES) :
              is_slow(rs_q, bus_q) ? TIMER_W'(CLEAR_WAIT) : TIMER_W'(CMD_WAIT);
    if (issue) begin
      step_d = init_pend ? step_q + 3'd1 : step_q;
      wrap_d = init_pend ? wrap_q : 1'b0;
      bus_d = init_pend ? init_cmd(step_q[1:0]) : wrap_q ? (line_q ? CMD_LINE0 : CMD_LINE1) : req_data;
      rs_d = !init_pend && !wrap_q && req_rs;
    end
    if (state_q == ST_HOLD) begin
      if (rs_q) begin
        col_d = col_q + 4'd1;
        wrap_d = col_q == 4'hF;
      end else if (bus_q == CMD_CLEAR || bus_q == CMD_HOME) begin
        col_d = 4'd0;
        line_d = 1'b0;
      end else if (bus_q[7]) begin
        col_d = bus_q[3:0];
        line_d = bus_q[6];
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      step_q <= '0;
      armed_q <= 1'b0;
      wrap_q <= 1'b0;
      init_done_q <= 1'b0;
      bus_q <= '0;
      rs_q <= 1'b0;
      e_q <= 1'b0;
      col_q <= '0;
      line_q <= 1'b0;
    end else begin
      step_q <= step_d;
      armed_q <= 1'b1;
      wrap_q <= wrap_d;
      init_done_q <= init_done_d;
      bus_q <= bus_d;
      rs_q <= rs_d;
      e_q <= e_d;
      col_q <= col_d;
      line_q <= line_d;
    end
  assign req_ready = state_q == ST_IDLE;
  assign init_done = init_done_q;
  assign cursor_col = col_q;
  assign cursor_line = line_q;
  assign lcd_data_bus = bus_q;
  assign lcd_rs = rs_q;
  assign lcd_rw = 1'b0;
  assign lcd_e = e_q;
endmodule
